// File: rtl/bus_mem_port_if.sv
// bus_mem_port_if: control strobes, status and external-memory handshake
// signals of the bus_mem_port responder. The shared tri-state CPU bus stays
// a plain inout port on the module so that its resolution is done on an
// ordinary net rather than through an interface.
//
// Handshake (memory side): mem_req/mem_we/mem_addr/mem_wdata are raised by
// the responder and held stable until the memory samples mem_ready high on
// a rising clock edge; that edge completes the transfer (mem_rdata is taken
// on the same edge for reads). mem_ready while mem_req is low is ignored.
interface bus_mem_port_if;
  logic        addr_wr;
  logic        addr_inc;
  logic        data_wr;
  logic        start_rd;
  logic        data_rd;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  // responder side (the memory port itself)
  modport slave (
    input  addr_wr, addr_inc, data_wr, start_rd, data_rd, mem_ready, mem_rdata,
    output busy, done, err, mem_req, mem_we, mem_addr, mem_wdata
  );

  // control-unit / memory side
  modport master (
    output addr_wr, addr_inc, data_wr, start_rd, data_rd, mem_ready, mem_rdata,
    input  busy, done, err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/bus_mem_port.sv
// bus_mem_port: memory-side responder on the shared 32-bit CPU bus.
// Latches an address (MAR) and write data (WDR) from the bus, runs one
// single-word read or write per command over mem_req/mem_ready, and drives
// the read-data register (RDR) onto the bus when data_rd is strobed.
// Optional feature macro: ALIGN_CHECK_EN (reject misaligned starts, set the
// sticky err flag). Without it err is tied low and MAR[1:0] pass through.
module bus_mem_port (
  input  logic          clk,
  input  logic          rst_n,
  inout  wire  [31:0]   bus,
  bus_mem_port_if.slave bif,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] mar, mar_nxt;
  logic [31:0] wdr, wdr_nxt;
  logic [31:0] rdr, rdr_nxt;
  logic        we_q, we_nxt;
  logic        done_q, done_nxt;
  logic        misaligned;

`ifdef ALIGN_CHECK_EN
  logic        err_q, err_nxt;
`endif

  // Register update; reset aborts any transaction immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mar    <= 32'h0;
      wdr    <= 32'h0;
      rdr    <= 32'h0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      mar    <= mar_nxt;
      wdr    <= wdr_nxt;
      rdr    <= rdr_nxt;
      we_q   <= we_nxt;
      done_q <= done_nxt;
    end
  end

`ifdef ALIGN_CHECK_EN
  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_nxt;
    end
  end

  // The check uses the address the access would actually go to, so an
  // addr_wr in the same cycle as the start is taken into account.
  always_comb begin
    misaligned = 1'b0;
    err_nxt    = err_q;
    if (state == IDLE && (bif.data_wr || bif.start_rd) && (mar_nxt[1:0] != 2'b00)) begin
      misaligned = 1'b1;
      err_nxt    = 1'b1;
    end
  end

  assign bif.err = err_q;
`else
  // Without the alignment check every start goes to memory as addressed.
  always_comb begin
    misaligned = 1'b0;
  end

  assign bif.err = 1'b0;
`endif

  // Next-state, register loads and done pulse; commands only act in IDLE.
  always_comb begin
    state_nxt = state;
    mar_nxt   = mar;
    wdr_nxt   = wdr;
    rdr_nxt   = rdr;
    we_nxt    = we_q;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // addr_inc wins over addr_wr; increment wraps naturally at 2^32.
        if (bif.addr_inc) begin
          mar_nxt = mar + 32'd4;
        end else if (bif.addr_wr) begin
          mar_nxt = bus;
        end
        if (bif.data_wr) begin
          wdr_nxt = bus;
        end
        if (misaligned) begin
          done_nxt = 1'b1;
        end else if (bif.data_wr) begin
          we_nxt    = 1'b1;
          state_nxt = WRITE;
        end else if (bif.start_rd) begin
          we_nxt    = 1'b0;
          state_nxt = READ;
        end
      end
      READ, WRITE: begin
        if (bif.mem_ready) begin
          if (state == READ) begin
            rdr_nxt = bif.mem_rdata;
          end
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bif.busy      = (state != IDLE);
  assign bif.mem_req   = (state != IDLE);
  assign bif.mem_we    = we_q;
  assign bif.mem_addr  = mar;
  assign bif.mem_wdata = wdr;
  assign bif.done      = done_q;
  assign dbg_state     = state;

  // RDR goes onto the shared bus only while the control unit asks for it.
  assign bus = bif.data_rd ? rdr : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_bus_mem_port.sv
// tb_bus_mem_port: directed bench for bus_mem_port with a transaction-level
// reference model checked every cycle, plus literal expectations.
module tb_bus_mem_port;

  logic        clk;
  logic        rst_n;
  logic [31:0] bus_drv;
  logic        bus_oe;
  wire  [31:0] bus;
  logic [1:0]  dbg_state;

  bus_mem_port_if bif ();

  assign bus = bus_oe ? bus_drv : 32'hzzzz_zzzz;

  bus_mem_port dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .bif       (bif),
    .dbg_state (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int req_cnt  = 0;
  int d0, r0;

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction at most, described by the
  // command rules rather than by the design's state machine.
  logic [31:0] m_mar = 0, m_wdr = 0, m_rdr = 0;
  logic        m_busy = 0, m_is_rd = 0, m_done = 0, m_err = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mar = 0; m_wdr = 0; m_rdr = 0;
      m_busy = 0; m_is_rd = 0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (bif.addr_inc)     m_mar = m_mar + 32'd4;
        else if (bif.addr_wr) m_mar = bus;
        if (bif.data_wr)      m_wdr = bus;
        if (bif.data_wr || bif.start_rd) begin
`ifdef ALIGN_CHECK_EN
          if (m_mar % 4 != 0) begin
            m_err  = 1;
            m_done = 1;
          end else begin
            m_busy  = 1;
            m_is_rd = !bif.data_wr;
          end
`else
          m_busy  = 1;
          m_is_rd = !bif.data_wr;
`endif
        end
      end else if (bif.mem_ready) begin
        if (m_is_rd) m_rdr = bif.mem_rdata;
        m_busy = 0;
        m_done = 1;
      end
    end
  end

  // Scoreboard compare, sampled away from the rising edge every cycle.
  always @(posedge clk) begin
    #2;
    chk("busy", {31'b0, bif.busy}, {31'b0, m_busy});
    chk("done", {31'b0, bif.done}, {31'b0, m_done});
    chk("err", {31'b0, bif.err}, {31'b0, m_err});
    chk("mem_req", {31'b0, bif.mem_req}, {31'b0, m_busy});
    if (m_busy) chk("mem_we", {31'b0, bif.mem_we}, {31'b0, !m_is_rd});
    chk("mem_addr", bif.mem_addr, m_mar);
    chk("mem_wdata", bif.mem_wdata, m_wdr);
    if (bif.data_rd) chk("bus_rdr", bus, m_rdr);
    if (bif.done) done_cnt++;
    if (bif.mem_req) req_cnt++;
  end

  // driver / directed sequence
  initial begin
    rst_n = 1'b0;
    bus_oe = 1'b1; bus_drv = 32'h1234_5678;
    bif.addr_wr = 0; bif.addr_inc = 0; bif.data_wr = 0; bif.start_rd = 0;
    bif.data_rd = 0; bif.mem_ready = 0; bif.mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'b0, bif.mem_req}, 32'h0);
    chk("rst_busy", {31'b0, bif.busy}, 32'h0);
    chk("rst_bus_not_driven", bus, 32'h1234_5678);
    rst_n = 1'b1;
    @(negedge clk);
    bus_oe = 0; bif.data_rd = 1;
    #1 chk("rst_rdr_on_bus", bus, 32'h0);

    // read with three-cycle memory latency
    @(negedge clk);
    bif.data_rd = 0; bif.addr_wr = 1; bus_oe = 1; bus_drv = 32'h0000_0100;
    @(negedge clk);
    bif.addr_wr = 0; bif.start_rd = 1; bus_oe = 0; d0 = done_cnt;
    @(negedge clk);
    bif.start_rd = 0;
    chk("rd_mem_addr", bif.mem_addr, 32'h100);
    chk("rd_mem_we", {31'b0, bif.mem_we}, 32'h0);
    chk("rd_mem_req", {31'b0, bif.mem_req}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    bif.mem_ready = 1; bif.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bif.mem_ready = 0; bif.mem_rdata = 0;
    chk("rd_done", {31'b0, bif.done}, 32'h1);
    @(negedge clk);
    chk("rd_done_pulses", done_cnt - d0, 32'd1);
    bif.data_rd = 1;
    #1 chk("rd_bus_data", bus, 32'hDEAD_BEEF);

    // write, memory ready immediately
    @(negedge clk);
    bif.data_rd = 0; bif.addr_wr = 1; bus_oe = 1; bus_drv = 32'h0000_0200;
    @(negedge clk);
    bif.addr_wr = 0; bif.data_wr = 1; bus_drv = 32'hCAFE_F00D;
    r0 = req_cnt; d0 = done_cnt;
    @(negedge clk);
    bif.data_wr = 0; bus_oe = 0; bif.mem_ready = 1;
    chk("wr_mem_we", {31'b0, bif.mem_we}, 32'h1);
    chk("wr_mem_wdata", bif.mem_wdata, 32'hCAFE_F00D);
    chk("wr_mem_addr", bif.mem_addr, 32'h200);
    @(negedge clk);
    bif.mem_ready = 0;
    @(negedge clk);
    chk("wr_req_cycles", req_cnt - r0, 32'd1);
    chk("wr_done_pulses", done_cnt - d0, 32'd1);

    // wrap and addr_inc-over-addr_wr priority
    bif.addr_wr = 1; bus_oe = 1; bus_drv = 32'hFFFF_FFFC;
    @(negedge clk);
    bif.addr_inc = 1; bus_drv = 32'h5555_5550;
    @(negedge clk);
    bif.addr_inc = 0; bif.addr_wr = 0; bus_oe = 0;
    chk("wrap_mar", bif.mem_addr, 32'h0);
    bif.addr_inc = 1;
    @(negedge clk);
    bif.addr_inc = 0;
    chk("inc_mar", bif.mem_addr, 32'h4);

    // data_wr wins over start_rd
    bif.start_rd = 1; bif.data_wr = 1; bus_oe = 1; bus_drv = 32'h1111_2222;
    @(negedge clk);
    bif.start_rd = 0; bif.data_wr = 0; bus_oe = 0;
    chk("prio_mem_we", {31'b0, bif.mem_we}, 32'h1);
    chk("prio_wdata", bif.mem_wdata, 32'h1111_2222);
    bif.mem_ready = 1;
    @(negedge clk);
    bif.mem_ready = 0;
    chk("prio_done", {31'b0, bif.done}, 32'h1);

    // mem_ready while idle is ignored
    @(negedge clk);
    bif.mem_ready = 1;
    @(negedge clk);
    bif.mem_ready = 0;
    chk("idle_ready_no_done", {31'b0, bif.done}, 32'h0);

    // commands ignored while busy, then reset mid-read
    bif.addr_wr = 1; bus_oe = 1; bus_drv = 32'h0000_0100;
    @(negedge clk);
    bif.addr_wr = 0; bif.start_rd = 1; bus_oe = 0;
    @(negedge clk);
    bif.start_rd = 0; bif.addr_wr = 1; bus_oe = 1; bus_drv = 32'h0000_0300;
    @(negedge clk);
    bif.addr_wr = 0; bus_oe = 0;
    chk("busy_mar_frozen", bif.mem_addr, 32'h100);
    chk("busy_held", {31'b0, bif.busy}, 32'h1);
    d0 = done_cnt;
    rst_n = 0;
    #1;
    chk("abort_mem_req", {31'b0, bif.mem_req}, 32'h0);
    chk("abort_mar", bif.mem_addr, 32'h0);
    bif.mem_ready = 1;
    @(negedge clk);
    rst_n = 1; bif.mem_ready = 0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 32'd0);

    // misaligned start
    bif.addr_wr = 1; bus_oe = 1; bus_drv = 32'h0000_0102;
    @(negedge clk);
    bif.addr_wr = 0; bif.start_rd = 1; bus_oe = 0; d0 = done_cnt;
    @(negedge clk);
    bif.start_rd = 0;
`ifdef ALIGN_CHECK_EN
    chk("mis_mem_req", {31'b0, bif.mem_req}, 32'h0);
    chk("mis_err", {31'b0, bif.err}, 32'h1);
    chk("mis_done", {31'b0, bif.done}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    chk("mis_done_pulses", done_cnt - d0, 32'd1);
    chk("mis_err_sticky", {31'b0, bif.err}, 32'h1);
`else
    chk("mis_mem_addr", bif.mem_addr, 32'h102);
    chk("mis_err", {31'b0, bif.err}, 32'h0);
    chk("mis_mem_req", {31'b0, bif.mem_req}, 32'h1);
    bif.mem_ready = 1; bif.mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    bif.mem_ready = 0; bif.mem_rdata = 0;
    @(negedge clk);
    chk("mis_err_after", {31'b0, bif.err}, 32'h0);
    bif.data_rd = 1;
    #1 chk("mis_bus_data", bus, 32'h0BAD_F00D);
    @(negedge clk);
    bif.data_rd = 0;
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_mem_port.md
# bus_mem_port

Memory-side responder on the shared 32-bit tri-state CPU bus. It latches an address and write data from the bus and performs single-word reads and writes to external memory over a req/ready handshake. It returns read data onto the bus when the control unit strobes it. It is the counterpart of the bus-driving registers (e.g. PC): those drive the bus, and this block consumes the address and supplies the instruction/data word.

## Interface
Parameters:
- none (data and address widths fixed at 32)

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- addr_wr  input  1  load address register (MAR) from bus
- addr_inc  input  1  MAR <= MAR + 4
- data_wr  input  1  load write-data register from bus and start memory write
- start_rd  input  1  start memory read at MAR
- data_rd  input  1  drive read-data register onto bus
- bus  inout  32  shared CPU bus; high-Z unless data_rd
- busy  output  1  transaction in progress
- done  output  1  one-cycle pulse at transaction completion
- err  output  1  sticky misaligned-access flag (see Configuration)
- mem_req  output  1  memory request, held until accepted
- mem_we  output  1  1 = write, 0 = read; valid while mem_req
- mem_addr  output  32  = MAR
- mem_wdata  output  32  = write-data register
- mem_ready  input  1  memory accepts/completes request this cycle
- mem_rdata  input  32  read data, valid when mem_ready and !mem_we

## Operation
- FSM states: IDLE, READ, WRITE.
- IDLE:
  - data_wr: WDR <= bus, mem_we <= 1, mem_req <= 1, go to WRITE.
  - Else start_rd: mem_we <= 0, mem_req <= 1, go to READ.
  - data_wr has priority over start_rd.
- addr_wr in IDLE: MAR <= bus.
- addr_inc in IDLE: MAR <= MAR + 4. Wraps modulo 2^32; 0xFFFFFFFC -> 0x00000000.
- addr_inc has priority over addr_wr.
- addr_wr together with start_rd: the read uses the bus value (MAR updated same edge; mem_addr reflects it).
- data_wr together with addr_wr is illegal (bus carries one value); behaviour is that both registers load the bus value.
- READ/WRITE: mem_req and mem_we held stable; MAR and WDR frozen.
  - On edge with mem_ready: READ captures RDR <= mem_rdata. Both return to IDLE, mem_req <= 0, done <= 1 for one cycle.
- While busy, addr_wr, addr_inc, data_wr and start_rd are ignored (no queuing).
- data_rd is honoured in any state: bus = RDR, else 'z. RDR holds its value until the next completed read.
- busy = (state != IDLE).

## Timing
- Reset (rst_n low, asynchronous):
  - state IDLE
  - MAR, WDR, RDR = 0
  - mem_req, mem_we, busy, done, err = 0
  - bus high-Z
- Reset mid-transaction aborts immediately; mem_req drops without waiting for mem_ready.
- Start sampled at edge N: mem_req and busy high after N.
- mem_ready sampled high at edge M >= N+1: done high during cycle M..M+1, busy low after M, RDR valid after M.
- Minimum read-to-bus latency: start_rd at edge N, mem_ready at N+1, data_rd usable in cycle after N+1.
- A new command may be issued in the same cycle done is high.
- mem_ready while mem_req low is ignored.

## Configuration
- ALIGN_CHECK_EN defined:
  - A start with MAR[1:0] != 0 does not assert mem_req.
  - FSM stays IDLE, sets err (sticky until reset) and pulses done next cycle.
  - RDR is unchanged.
- Undefined:
  - err tied 0; MAR[1:0] passed through on mem_addr unchanged.

## Test plan
- Reset: bus driven 0x12345678 by bench, rst_n low -> mem_req = 0, busy = 0, bus not driven by DUT; data_rd then drives 0x00000000.
- Read: addr_wr with bus = 0x00000100, start_rd, mem_ready after 3 cycles with mem_rdata = 0xDEADBEEF -> mem_addr = 0x100, mem_we = 0, single done pulse; data_rd drives 0xDEADBEEF.
- Write: addr_wr 0x200, data_wr bus = 0xCAFEF00D, mem_ready immediately -> mem_req high exactly one cycle, mem_we = 1, mem_wdata = 0xCAFEF00D, done one cycle.
- Wrap and priority: MAR = 0xFFFFFFFC, addr_inc and addr_wr together -> MAR = 0x00000000; start_rd and data_wr together -> write performed.
- Busy/abort: start_rd, then addr_wr 0x300 while busy -> mem_addr unchanged; rst_n pulsed mid-read -> mem_req low at once, done never pulses.
- With ALIGN_CHECK_EN: addr_wr 0x102, start_rd -> no mem_req, err = 1, done pulses once; without the macro -> mem_addr = 0x102 and err stays 0.
